// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - operand FIFO and one-at-a-time issue sequencer for the Booth MAC
// Optional watchdog with sticky seq_err when MACSEQ_TIMEOUT_EN is defined.
module mac_operand_sequencer #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_mc,
   input  logic [7:0]       in_mp,
   input  logic             in_last,
   output logic             mac_start,
   output logic [7:0]       mac_mc,
   output logic [7:0]       mac_mp,
   output logic             mac_clr,
   input  logic             mac_busy,
   output logic             vec_done,
   output logic [LEN_W-1:0] vec_count
`ifdef MACSEQ_TIMEOUT_EN
   ,
   output logic             seq_err
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_ARM   = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [16:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic [16:0]   head;
   logic [2:0]    state;
   logic [2:0]    next_state;
   logic          last_r;

   assign in_ready   = (count != FULL_CNT);
   assign fifo_empty = (count == '0);
   assign push       = in_valid & in_ready;
   assign head       = mem[rd_ptr];
   // The head is consumed on the edge that enters ISSUE.
   assign pop        = (next_state == S_ISSUE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_last, in_mc, in_mp};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef MACSEQ_TIMEOUT_EN
   // wd_cnt is 0 in the first WAIT cycle, so 23 marks the 24th busy WAIT cycle.
   localparam logic [4:0] WD_LIMIT = 5'd23;
   logic [4:0] wd_cnt;
   logic       wd_trip;
`endif

   always_comb begin
      next_state = state;
`ifdef MACSEQ_TIMEOUT_EN
      wd_trip = 1'b0;
`endif
      case (state)
         S_IDLE:  if (!fifo_empty) next_state = S_CLEAR;
         S_CLEAR: next_state = S_ISSUE;
         S_ISSUE: next_state = S_ARM;
         S_ARM:   next_state = S_WAIT;
         S_WAIT: begin
            if (!mac_busy) begin
               if (last_r)           next_state = S_DONE;
               else if (!fifo_empty) next_state = S_ISSUE;
               else                  next_state = S_HOLD;
            end
`ifdef MACSEQ_TIMEOUT_EN
            else if (wd_cnt == WD_LIMIT) begin
               wd_trip    = 1'b1;
               next_state = S_DONE;
            end
`endif
         end
         S_HOLD:  if (!fifo_empty) next_state = S_ISSUE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         mac_mc    <= '0;
         mac_mp    <= '0;
         last_r    <= 1'b0;
         vec_count <= '0;
      end else begin
         state <= next_state;
         if (next_state == S_CLEAR) begin
            vec_count <= '0;
         end
         if (pop) begin
            last_r <= head[16];
            mac_mc <= head[15:8];
            mac_mp <= head[7:0];
            if (vec_count != '1) begin
               vec_count <= vec_count + 1'b1;
            end
         end
      end
   end

`ifdef MACSEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt  <= '0;
         seq_err <= 1'b0;
      end else begin
         if (next_state == S_WAIT && state != S_WAIT) begin
            wd_cnt <= '0;
         end else if (state == S_WAIT && wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (wd_trip) begin
            seq_err <= 1'b1;
         end
      end
   end
`endif

   assign mac_clr   = (state == S_CLEAR);
   assign mac_start = (state == S_ISSUE);
   assign vec_done  = (state == S_DONE);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb/tb_mac_operand_sequencer.sv - self-checking bench for mac_operand_sequencer
// Behavioural MAC, queue-based dot-product model; MACSEQ_TIMEOUT_EN adds the watchdog steps.
module tb_mac_operand_sequencer;

   localparam int DEPTH = 4;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_mc;
   logic [7:0]       in_mp;
   logic             in_last;
   logic             mac_start;
   logic [7:0]       mac_mc;
   logic [7:0]       mac_mp;
   logic             mac_clr;
   logic             mac_busy;
   logic             vec_done;
   logic [LEN_W-1:0] vec_count;
`ifdef MACSEQ_TIMEOUT_EN
   logic             seq_err;
`endif

   typedef struct { int cyc; logic [7:0] mc; logic [7:0] mp; } start_t;
   typedef struct { int cyc; int cnt; int acc; } done_t;
   typedef struct { logic last; logic [7:0] mc; logic [7:0] mp; } pair_t;

   start_t start_q[$];
   int     clr_q[$];
   done_t  done_q[$];
   pair_t  exp_q[$];

   int cyc        = 0;
   int n_cmp      = 0;
   int n_bad      = 0;
   int mac_lat    = 8;
   bit rand_lat   = 1'b0;
   bit force_busy = 1'b0;
   int busy_cnt   = 0;
   int acc        = 0;

   mac_operand_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mc     (in_mc),
      .in_mp     (in_mp),
      .in_last   (in_last),
      .mac_start (mac_start),
      .mac_mc    (mac_mc),
      .mac_mp    (mac_mp),
      .mac_clr   (mac_clr),
      .mac_busy  (mac_busy),
      .vec_done  (vec_done),
      .vec_count (vec_count)
`ifdef MACSEQ_TIMEOUT_EN
      ,
      .seq_err   (seq_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural MAC: busy for mac_lat cycles after each start, accumulates signed products.
   always @(posedge clk) begin
      if (reset) begin
         busy_cnt <= 0;
         acc      <= 0;
      end else begin
         if (mac_clr) acc <= 0;
         if (mac_start) begin
            acc      <= acc + int'($signed(mac_mc)) * int'($signed(mac_mp));
            busy_cnt <= rand_lat ? int'($urandom_range(1, 12)) : mac_lat;
         end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end
   assign mac_busy = force_busy || (busy_cnt != 0);

   always @(negedge clk) begin
      if (!reset) begin
         if (mac_start) start_q.push_back('{cyc, mac_mc, mac_mp});
         if (mac_clr)   clr_q.push_back(cyc);
         if (vec_done)  done_q.push_back('{cyc, int'(vec_count), acc});
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [7:0] mc, input logic [7:0] mp, input logic last, output int t);
      int n = 0;
      in_valid = 1'b1;
      in_mc    = mc;
      in_mp    = mp;
      in_last  = last;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      if (in_ready) begin
         exp_q.push_back('{last, mc, mp});
         @(negedge clk);
      end else begin
         chk("push_timeout", 0, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int n, input int budget);
      int k = 0;
      while (done_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      idle(3);
   endtask

   task automatic clear_all();
      start_q.delete();
      clr_q.delete();
      done_q.delete();
      exp_q.delete();
   endtask

   // Splits the accepted pairs into vectors and compares issue order, counts and dot products.
   task automatic verify(input string tag);
      int cnt = 0;
      int dot = 0;
      int exp_cnt[$];
      int exp_acc[$];
      foreach (exp_q[k]) begin
         cnt++;
         dot += int'($signed(exp_q[k].mc)) * int'($signed(exp_q[k].mp));
         if (exp_q[k].last) begin
            exp_cnt.push_back(cnt);
            exp_acc.push_back(dot);
            cnt = 0;
            dot = 0;
         end
      end
      chk({tag, "_n_start"}, start_q.size(), exp_q.size());
      chk({tag, "_n_clr"}, clr_q.size(), exp_cnt.size());
      chk({tag, "_n_done"}, done_q.size(), exp_cnt.size());
      for (int k = 0; k < exp_q.size() && k < start_q.size(); k++)
         chk($sformatf("%s_pair%0d", tag, k), {start_q[k].mc, start_q[k].mp}, {exp_q[k].mc, exp_q[k].mp});
      for (int k = 0; k < exp_cnt.size() && k < done_q.size(); k++) begin
         chk($sformatf("%s_vec%0d_count", tag, k), done_q[k].cnt, exp_cnt[k]);
         chk($sformatf("%s_vec%0d_acc", tag, k), done_q[k].acc, exp_acc[k]);
      end
      clear_all();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      int t0;
      int len;
      logic [7:0] mc6;
      logic [7:0] mp6;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_mc    = '0;
      in_mp    = '0;
      in_last  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_mac_start", mac_start, 0);
      chk("rst_mac_clr", mac_clr, 0);
      chk("rst_vec_done", vec_done, 0);
      chk("rst_vec_count", vec_count, 0);
      chk("rst_mac_mc", mac_mc, 0);
      chk("rst_mac_mp", mac_mp, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef MACSEQ_TIMEOUT_EN
      chk("rst_seq_err", seq_err, 0);
`endif
      reset = 1'b0;
      idle(2);

      // Single pair 3 * -4
      push(8'h03, 8'hFC, 1'b1, t);
      wait_done(1, 100);
      chk("single_clr_cyc", clr_q.size() > 0 ? clr_q[0] : -1, t + 2);
      chk("single_start_cyc", start_q.size() > 0 ? start_q[0].cyc : -1, t + 3);
      chk("single_mac_mc", start_q.size() > 0 ? int'(start_q[0].mc) : -1, 8'h03);
      chk("single_mac_mp", start_q.size() > 0 ? int'(start_q[0].mp) : -1, 8'hFC);
      chk("single_done_cyc", done_q.size() > 0 ? done_q[0].cyc : -1, t + 13);
      chk("single_acc", done_q.size() > 0 ? done_q[0].acc : -1, -12);
      chk("single_count_hold", vec_count, 1);
      verify("single");

      // Four-element vector then a one-element vector, all back-to-back
      t0 = 0;
      for (int k = 0; k < 4; k++) begin
         push(8'($urandom), 8'($urandom), k == 3, t);
         if (k == 0) t0 = t;
      end
      push(8'h80, 8'h80, 1'b1, t);
      wait_done(2, 400);
      if (start_q.size() >= 5 && done_q.size() >= 2 && clr_q.size() >= 2) begin
         chk("vec4_first_start", start_q[0].cyc, t0 + 3);
         for (int k = 1; k < 4; k++)
            chk($sformatf("vec4_period%0d", k), start_q[k].cyc - start_q[k-1].cyc, 10);
         chk("vec4_done_cyc", done_q[0].cyc, start_q[3].cyc + 10);
         chk("b2b_done_to_clr", clr_q[1] - done_q[0].cyc, 2);
      end else begin
         chk("vec4_event_count", start_q.size(), 5);
      end
      verify("vec4");

      // MAC stalled: FIFO fills, in_ready drops, nothing lost or duplicated
      force_busy = 1'b1;
      for (int k = 0; k < DEPTH + 1; k++)
         push(8'($urandom), 8'($urandom), 1'b0, t);
      mc6      = 8'($urandom);
      mp6      = 8'($urandom);
      in_valid = 1'b1;
      in_mc    = mc6;
      in_mp    = mp6;
      in_last  = 1'b1;
      idle(8);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_one_outstanding", start_q.size(), 1);
      force_busy = 1'b0;
      push(mc6, mp6, 1'b1, t);
      wait_done(1, 500);
      verify("stall");

      // Mid-vector gap: HOLD without an extra clear
      push(8'($urandom), 8'($urandom), 1'b0, t);
      push(8'($urandom), 8'($urandom), 1'b0, t);
      idle(40);
      chk("hold_no_early_done", done_q.size(), 0);
      push(8'($urandom), 8'($urandom), 1'b1, t);
      wait_done(1, 200);
      verify("hold");

      // Reset in WAIT of element 2
      for (int k = 0; k < 3; k++)
         push(8'($urandom), 8'($urandom), k == 2, t);
      for (int k = 0; k < 100 && start_q.size() < 2; k++) @(negedge clk);
      idle(3);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_mac_start", mac_start, 0);
      chk("mid_rst_mac_clr", mac_clr, 0);
      chk("mid_rst_vec_done", vec_done, 0);
      chk("mid_rst_vec_count", vec_count, 0);
      chk("mid_rst_mac_mc", mac_mc, 0);
      chk("mid_rst_mac_mp", mac_mp, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      reset = 1'b0;
      clear_all();
      idle(2);
      push(8'($urandom), 8'($urandom), 1'b0, t);
      push(8'($urandom), 8'($urandom), 1'b1, t);
      wait_done(1, 200);
      chk("post_rst_clr_first", (clr_q.size() > 0 && start_q.size() > 0) ? int'(clr_q[0] < start_q[0].cyc) : 0, 1);
      verify("post_rst");

      // Random vectors, random gaps and MAC latency
      rand_lat = 1'b1;
      for (int v = 0; v < 6; v++) begin
         len = int'($urandom_range(1, 5));
         for (int e = 0; e < len; e++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 25)));
            push(8'($urandom), 8'($urandom), e == len - 1, t);
         end
      end
      wait_done(6, 3000);
      verify("rand");
      rand_lat = 1'b0;

`ifdef MACSEQ_TIMEOUT_EN
      force_busy = 1'b1;
      push(8'($urandom), 8'($urandom), 1'b1, t);
      wait_done(1, 200);
      chk("wd_seq_err", seq_err, 1);
      chk("wd_done", done_q.size(), 1);
      chk("wd_count", done_q.size() > 0 ? done_q[0].cnt : -1, 1);
      idle(5);
      chk("wd_seq_err_sticky", seq_err, 1);
      force_busy = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("wd_seq_err_reset", seq_err, 0);
      reset = 1'b0;
      clear_all();
      idle(2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
